// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode stage with register file, load-use hazard
// detection and an ID/EX pipeline register.
// Optional feature: define ID_BYPASS_EN for write-through bypass from write-back
// onto the read ports; otherwise reads return pre-write register contents.
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       if_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_p0,
  output logic [DATA_W-1:0] ex_p1,
  output logic [7:0]        ex_imm8,
  output logic [3:0]        ex_shamt,
  output logic [2:0]        ex_func,
  output logic              ex_src1sel,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic              ex_we,
  output logic [ADDR_W-1:0] ex_dst_addr,
  output logic              ex_hlt
);

  localparam logic [3:0] OpLw  = 4'b1000;
  localparam logic [3:0] OpSw  = 4'b1001;
  localparam logic [3:0] OpLlb = 4'b1010;
  localparam logic [3:0] OpHlt = 4'b1111;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] p0;
    logic [DATA_W-1:0] p1;
    logic [7:0]        imm8;
    logic [3:0]        shamt;
    logic [2:0]        func;
    logic              src1sel;
    logic              mem_rd;
    logic              mem_wr;
    logic              we;
    logic [ADDR_W-1:0] dst;
    logic              hlt;
  } idex_t;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  idex_t             idex_q, idex_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd_a, rs_a, rt_a, p0_addr, p1_addr;
  logic              reads_p0, reads_p1;
  logic [2:0]        dec_func;
  logic              dec_src1sel, dec_mem_rd, dec_mem_wr, dec_we, dec_hlt;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              hazard, load_bubble;

  assign op      = if_instr[15:12];
  assign rd_a    = if_instr[8 +: ADDR_W];
  assign rs_a    = if_instr[4 +: ADDR_W];
  assign rt_a    = if_instr[0 +: ADDR_W];
  assign p0_addr = rs_a;
  // Stores read the data register through the second port.
  assign p1_addr = (op == OpSw) ? rd_a : rt_a;

  // Instruction decode: which sources are read and which controls are raised
  always_comb begin
    reads_p0    = 1'b0;
    reads_p1    = 1'b0;
    dec_func    = 3'b000;
    dec_src1sel = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_we      = 1'b0;
    dec_hlt     = 1'b0;
    if (!op[3]) begin
      reads_p0 = 1'b1;
      // Shifts (101..111) take their amount from the rt field, not a register.
      reads_p1 = !(op[2] && (op[1] || op[0]));
      dec_func = op[2:0];
      dec_we   = 1'b1;
    end else begin
      unique case (op)
        OpLw: begin
          reads_p0    = 1'b1;
          dec_src1sel = 1'b1;
          dec_mem_rd  = 1'b1;
          dec_we      = 1'b1;
        end
        OpSw: begin
          reads_p0    = 1'b1;
          reads_p1    = 1'b1;
          dec_src1sel = 1'b1;
          dec_mem_wr  = 1'b1;
        end
        OpLlb: begin
          dec_src1sel = 1'b1;
          dec_we      = 1'b1;
        end
        OpHlt:   dec_hlt = 1'b1;
        default: ;
      endcase
    end
  end

  // Register-file read ports; register 0 is hardwired to zero
  always_comb begin
    rd0_data = (p0_addr == '0) ? '0 : rf_q[p0_addr];
    rd1_data = (p1_addr == '0) ? '0 : rf_q[p1_addr];
`ifdef ID_BYPASS_EN
    if (wb_we && (wb_addr != '0) && (wb_addr == p0_addr)) rd0_data = wb_data;
    if (wb_we && (wb_addr != '0) && (wb_addr == p1_addr)) rd1_data = wb_data;
`endif
  end

  // Load-use hazard and stall generation
  always_comb begin
    hazard = idex_q.valid && idex_q.mem_rd && (idex_q.dst != '0) &&
             ((reads_p0 && (p0_addr == idex_q.dst)) ||
              (reads_p1 && (p1_addr == idex_q.dst)));
    // A flush squashes the stalled instruction, so fetch may move on.
    id_stall    = idex_q.hlt || (if_valid && hazard && !flush);
    load_bubble = !if_valid || flush || hazard;
  end

  // ID/EX next state: freeze on halt, bubble on hazard/flush/invalid
  always_comb begin
    idex_d = '0;
    if (idex_q.hlt) begin
      idex_d = idex_q;
    end else if (!load_bubble && dec_hlt) begin
      idex_d.hlt = 1'b1;
    end else if (!load_bubble) begin
      idex_d.valid   = 1'b1;
      idex_d.p0      = rd0_data;
      idex_d.p1      = rd1_data;
      idex_d.imm8    = if_instr[7:0];
      idex_d.shamt   = if_instr[3:0];
      idex_d.func    = dec_func;
      idex_d.src1sel = dec_src1sel;
      idex_d.mem_rd  = dec_mem_rd;
      idex_d.mem_wr  = dec_mem_wr;
      idex_d.we      = dec_we;
      idex_d.dst     = rd_a;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  // Register file write from write-back; continues during halt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign ex_valid    = idex_q.valid;
  assign ex_p0       = idex_q.p0;
  assign ex_p1       = idex_q.p1;
  assign ex_imm8     = idex_q.imm8;
  assign ex_shamt    = idex_q.shamt;
  assign ex_func     = idex_q.func;
  assign ex_src1sel  = idex_q.src1sel;
  assign ex_mem_rd   = idex_q.mem_rd;
  assign ex_mem_wr   = idex_q.mem_wr;
  assign ex_we       = idex_q.we;
  assign ex_dst_addr = idex_q.dst;
  assign ex_hlt      = idex_q.hlt;

endmodule
